// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts spikes from a LIF neuron over a fixed window of
// clock cycles. Each window yields a saturated rate sample and an
// exponentially smoothed rate, both presented downstream through valid/ready.
module spike_rate_decoder #(
    parameter int unsigned WINDOW   = 256,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned ALPHA_SH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike_in,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_sat,
    output logic [CNT_W-1:0] ema_out,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun
);

    localparam int unsigned WIN_W = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t             state;
    logic [WIN_W-1:0]   win_cnt;
    logic [CNT_W-1:0]   spk_cnt;
    logic               sat_flag;

    logic [CNT_W:0]     spk_sum;
    logic               spk_ovf;
    logic [CNT_W-1:0]   spk_next;
    logic               sat_next;
    logic signed [CNT_W:0]   ema_diff;
    logic signed [CNT_W:0]   ema_step;
    logic signed [CNT_W+1:0] ema_sum;
    logic [CNT_W-1:0]   ema_new;
    logic               win_close;
    logic               accept;

    // Saturating spike count including this cycle's sample, and the EMA update
    // that would be committed if this edge closes the window.
    always_comb begin
        spk_sum  = {1'b0, spk_cnt} + (CNT_W + 1)'(spike_in);
        spk_ovf  = spk_sum[CNT_W];
        spk_next = spk_ovf ? CNT_MAX : spk_sum[CNT_W-1:0];
        sat_next = sat_flag | spk_ovf;

        ema_diff = $signed({1'b0, spk_next}) - $signed({1'b0, ema_out});
        ema_step = ema_diff >>> ALPHA_SH;
        ema_sum  = $signed({2'b00, ema_out}) + $signed({ema_step[CNT_W], ema_step});
        if (ema_sum[CNT_W+1]) begin
            ema_new = '0;
        end else if (ema_sum[CNT_W]) begin
            ema_new = CNT_MAX;
        end else begin
            ema_new = ema_sum[CNT_W-1:0];
        end

        win_close = (state == COUNT) && enable && (win_cnt == WIN_LAST);
        accept    = rate_valid && rate_ready;
    end

    // Window FSM: counts spikes while enabled, commits rate/EMA at window close.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            win_cnt  <= '0;
            spk_cnt  <= '0;
            sat_flag <= 1'b0;
            rate_out <= '0;
            rate_sat <= 1'b0;
            ema_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    win_cnt  <= '0;
                    spk_cnt  <= '0;
                    sat_flag <= 1'b0;
                    if (enable) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        state    <= IDLE;
                        win_cnt  <= '0;
                        spk_cnt  <= '0;
                        sat_flag <= 1'b0;
                    end else if (win_close) begin
                        rate_out <= spk_next;
                        rate_sat <= sat_next;
                        ema_out  <= ema_new;
                        win_cnt  <= '0;
                        spk_cnt  <= '0;
                        sat_flag <= 1'b0;
                    end else begin
                        win_cnt  <= win_cnt + WIN_W'(1);
                        spk_cnt  <= spk_next;
                        sat_flag <= sat_next;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output handshake: a new sample wins over a same-edge acceptance; a sample
    // overwritten before consumption raises the sticky overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (win_close) begin
            rate_valid <= 1'b1;
            if (rate_valid && !rate_ready) begin
                overrun <= 1'b1;
            end
        end else if (accept) begin
            rate_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: directed scenarios plus random traffic, checked
// by a window-level reference model feeding a scoreboard queue.
module tb_spike_rate_decoder;

    localparam int unsigned W1  = 16;
    localparam int unsigned C1  = 8;
    localparam int unsigned W2  = 32;
    localparam int unsigned C2  = 4;
    localparam int unsigned SH  = 2;
    localparam int          MAX1 = (1 << C1) - 1;

    typedef struct {
        int rate;
        int sat;
        int ema;
    } sample_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic spike_in = 1'b0;
    logic rate_ready = 1'b0;
    logic [C1-1:0] rate_out;
    logic rate_sat;
    logic [C1-1:0] ema_out;
    logic rate_valid;
    logic overrun;

    logic enable2 = 1'b0;
    logic spike2 = 1'b0;
    logic ready2 = 1'b1;
    logic [C2-1:0] rate2;
    logic sat2;
    logic [C2-1:0] ema2;
    logic valid2;
    logic overrun2;

    int n_checks = 0;
    int n_fail = 0;

    // reference model state
    sample_t exp_q[$];
    int  m_active = 0, m_cycles = 0, m_spikes = 0;
    int  m_rate = 0, m_sat = 0, m_ema = 0, m_valid = 0, m_overrun = 0;

    spike_rate_decoder #(.WINDOW(W1), .CNT_W(C1), .ALPHA_SH(SH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
        .rate_out(rate_out), .rate_sat(rate_sat), .ema_out(ema_out),
        .rate_valid(rate_valid), .rate_ready(rate_ready), .overrun(overrun)
    );

    spike_rate_decoder #(.WINDOW(W2), .CNT_W(C2), .ALPHA_SH(SH)) dut2 (
        .clk(clk), .reset(reset), .enable(enable2), .spike_in(spike2),
        .rate_out(rate2), .rate_sat(sat2), .ema_out(ema2),
        .rate_valid(valid2), .rate_ready(ready2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // EMA: ema + floor((rate - ema) / 2^SH), clamped to the output range
    function automatic int ema_next(input int ema, input int rate, input int cmax);
        int d, den, q;
        d   = rate - ema;
        den = 1 << SH;
        q   = d / den;
        if (d < 0 && (d % den) != 0) q = q - 1;
        q = ema + q;
        if (q < 0) q = 0;
        if (q > cmax) q = cmax;
        return q;
    endfunction

    // Reference model: tracks windows by counting sampled cycles and spikes.
    always @(posedge clk or negedge reset) begin
        sample_t s;
        int closed;
        if (!reset) begin
            m_active = 0; m_cycles = 0; m_spikes = 0;
            m_rate = 0; m_sat = 0; m_ema = 0; m_valid = 0; m_overrun = 0;
            exp_q.delete();
        end else begin
            closed = 0;
            if (m_active == 0) begin
                m_active = enable ? 1 : 0;
                m_cycles = 0;
                m_spikes = 0;
            end else if (!enable) begin
                m_active = 0;
            end else begin
                m_spikes = m_spikes + (spike_in ? 1 : 0);
                m_cycles = m_cycles + 1;
                if (m_cycles == W1) begin
                    closed   = 1;
                    m_rate   = (m_spikes > MAX1) ? MAX1 : m_spikes;
                    m_sat    = (m_spikes > MAX1) ? 1 : 0;
                    m_ema    = ema_next(m_ema, m_rate, MAX1);
                    m_cycles = 0;
                    m_spikes = 0;
                end
            end
            if (closed != 0) begin
                if (m_valid != 0 && !rate_ready) begin
                    m_overrun = 1;
                    if (exp_q.size() > 0) void'(exp_q.pop_back());
                end
                m_valid = 1;
                s.rate = m_rate; s.sat = m_sat; s.ema = m_ema;
                exp_q.push_back(s);
            end else if (m_valid != 0 && rate_ready) begin
                m_valid = 0;
            end
        end
    end

    // Monitor: compares outputs each cycle, pops the scoreboard on each transfer.
    always @(negedge clk) begin
        sample_t s;
        chk("valid", 32'(rate_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_overrun));
        chk("rate_hold", 32'(rate_out), 32'(m_rate));
        chk("sat_hold", 32'(rate_sat), 32'(m_sat));
        chk("ema_hold", 32'(ema_out), 32'(m_ema));
        if (rate_valid && rate_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_depth", 32'(exp_q.size()), 32'd1);
            end else begin
                s = exp_q.pop_front();
                chk("sb_rate", 32'(rate_out), 32'(s.rate));
                chk("sb_sat", 32'(rate_sat), 32'(s.sat));
                chk("sb_ema", 32'(ema_out), 32'(s.ema));
            end
        end
    end

    task automatic drive(input logic en, input logic spk, input logic rdy);
        enable     = en;
        spike_in   = spk;
        rate_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dens;
        // asynchronous reset with no clock edge yet
        #2;
        chk("rst_rate", 32'(rate_out), 32'd0);
        chk("rst_ema", 32'(ema_out), 32'd0);
        chk("rst_valid", 32'(rate_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1);

        // spike every 4th cycle, ready held high
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) drive(1'b1, (i % 4) == 3, 1'b1);
        chk("w1_rate", 32'(rate_out), 32'd4);
        chk("w1_ema", 32'(ema_out), 32'd1);
        chk("w1_valid", 32'(rate_valid), 32'd1);
        for (int i = 0; i < 16; i++) drive(1'b1, (i % 4) == 3, 1'b1);
        chk("w2_rate", 32'(rate_out), 32'd4);
        chk("w2_ema", 32'(ema_out), 32'd1);
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b1);
        chk("w3_rate", 32'(rate_out), 32'd0);
        chk("w3_ema", 32'(ema_out), 32'd0);
        drive(1'b0, 1'b0, 1'b1);

        // consumer stalls across two windows: second sample overwrites first
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b1, i < 5, 1'b0);
        chk("ovr_first", 32'(rate_out), 32'd5);
        for (int i = 0; i < 16; i++) drive(1'b1, i < 7, 1'b0);
        chk("ovr_rate", 32'(rate_out), 32'd7);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_valid", 32'(rate_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b1);
        chk("ovr_drop", 32'(rate_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // reset asserted mid-window clears everything without a clock edge
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        #2;
        chk("mid_rst_rate", 32'(rate_out), 32'd0);
        chk("mid_rst_ema", 32'(ema_out), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_valid", 32'(rate_valid), 32'd0);
        enable = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b1);

        // enable dropped mid-window discards the partial count
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b1, i < 3, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        chk("abort_valid", 32'(rate_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("early_valid", 32'(rate_valid), 32'd0);
            drive(1'b1, (i == 4) || (i == 9), 1'b1);
        end
        chk("reen_rate", 32'(rate_out), 32'd2);
        chk("reen_valid", 32'(rate_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b1);

        // acceptance on the exact closing edge: new sample, no overrun
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b1, i < 6, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b1, i < 9, i == 15);
        chk("edge_valid", 32'(rate_valid), 32'd1);
        chk("edge_rate", 32'(rate_out), 32'd9);
        chk("edge_overrun", 32'(overrun), 32'd0);
        drive(1'b0, 1'b0, 1'b1);

        // random traffic
        dens = 50;
        for (int i = 0; i < 800; i++) begin
            if ((i % 64) == 0) dens = int'($urandom_range(0, 100));
            drive($urandom_range(0, 99) < 93,
                  $urandom_range(0, 99) < dens,
                  $urandom_range(0, 99) < 60);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // narrow counter instance: saturation and recovery
        enable2 = 1'b1;
        spike2  = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            spike2 = 1'b1;
            drive(1'b0, 1'b0, 1'b1);
        end
        chk("sat_rate", 32'(rate2), 32'd15);
        chk("sat_flag", 32'(sat2), 32'd1);
        chk("sat_ema", 32'(ema2), 32'd3);
        chk("sat_valid", 32'(valid2), 32'd1);
        for (int i = 0; i < 32; i++) begin
            spike2 = (i < 3);
            drive(1'b0, 1'b0, 1'b1);
        end
        chk("unsat_rate", 32'(rate2), 32'd3);
        chk("unsat_flag", 32'(sat2), 32'd0);
        chk("unsat_ema", 32'(ema2), 32'd3);
        chk("unsat_overrun", 32'(overrun2), 32'd0);
        enable2 = 1'b0;
        drive(1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
